// File: rtl/rename_pkg.sv
// Shared rename types: width defaults, register index, ROB tag and the {busy, tag} entry.
package rename_pkg;
  localparam int RN_XLEN  = 32;
  localparam int RN_NREG  = 32;
  localparam int RN_TAG_W = 4;
  localparam int RN_REG_W = $clog2(RN_NREG);

  typedef logic [RN_REG_W-1:0] reg_idx_t;
  typedef logic [RN_TAG_W-1:0] rob_tag_t;
  typedef struct packed {
    logic     busy;
    rob_tag_t tag;
  } rn_entry_t;
  typedef rn_entry_t [RN_NREG-1:0] rn_table_t;

  // A commit of (crd, ctag) retires the producer recorded in entry e of register idx.
  function automatic logic commit_hits(input logic cv, input reg_idx_t crd, input rob_tag_t ctag,
                                       input reg_idx_t idx, input rn_entry_t e);
    return cv && (crd == idx) && (crd != '0) && (e.tag == ctag);
  endfunction
endpackage

// File: rtl/reg_rename_file_ckpt_bank.sv
// Circular bank of rename-table checkpoints with head/tail/count bookkeeping and commit scrub.
module ckpt_bank import rename_pkg::*; #(
  parameter int NCKPT = 4,
  localparam int PW = $clog2(NCKPT),
  localparam int CW = $clog2(NCKPT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rdy,
  input  logic          i_flush,
  input  logic          i_take,
  input  logic          i_release,
  input  logic          i_restore,
  input  logic [PW-1:0] i_restore_id,
  input  logic          i_commit_valid,
  input  reg_idx_t      i_commit_rd,
  input  rob_tag_t      i_commit_tag,
  input  rn_table_t     i_table,
  output rn_table_t     o_snap,
  output logic [PW-1:0] o_tail,
  output logic          o_full
);
  rn_table_t     r_snap [NCKPT];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_do_take;
  logic          w_do_rel;
  logic [PW-1:0] w_head_n;
  logic [PW-1:0] w_keep;

  assign o_full    = (r_count == CW'(NCKPT));
  assign o_tail    = r_tail;
  assign w_do_rel  = i_release && (r_count != '0);
  assign w_do_take = i_take && !o_full;
  assign w_head_n  = r_head + PW'(w_do_rel);
  assign w_keep    = i_restore_id - w_head_n;

  // Restored table already reflects this cycle's commit.
  always_comb begin
    o_snap = r_snap[i_restore_id];
    for (int r = 0; r < RN_NREG; r++) begin
      if (commit_hits(i_commit_valid, i_commit_rd, i_commit_tag, reg_idx_t'(r), r_snap[i_restore_id][r])) begin
        o_snap[r].busy = 1'b0;
      end else begin
        o_snap[r].busy = r_snap[i_restore_id][r].busy;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCKPT; k++) r_snap[k] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_rdy) begin
      for (int k = 0; k < NCKPT; k++) begin
        for (int r = 0; r < RN_NREG; r++) begin
          if (commit_hits(i_commit_valid, i_commit_rd, i_commit_tag, reg_idx_t'(r), r_snap[k][r]))
            r_snap[k][r].busy <= 1'b0;
        end
      end
      if (i_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else if (i_restore) begin
        r_head  <= w_head_n;
        r_tail  <= i_restore_id;
        r_count <= CW'(w_keep);
      end else begin
        // A fresh snapshot overrides the scrub of the slot it lands in.
        if (w_do_take) r_snap[r_tail] <= i_table;
        r_head  <= w_head_n;
        r_tail  <= r_tail + PW'(w_do_take);
        r_count <= r_count + CW'(w_do_take) - CW'(w_do_rel);
      end
    end
  end

  ckpt_bank_chk #(.NCKPT(NCKPT)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .i_rdy       (i_rdy),
    .i_flush     (i_flush),
    .i_restore   (i_restore),
    .i_restore_id(i_restore_id),
    .i_head      (r_head),
    .i_count     (r_count)
  );
endmodule

module ckpt_bank_chk #(
  parameter int NCKPT = 4,
  localparam int PW = $clog2(NCKPT),
  localparam int CW = $clog2(NCKPT + 1)
) (
  input logic          clk,
  input logic          rst,
  input logic          i_rdy,
  input logic          i_flush,
  input logic          i_restore,
  input logic [PW-1:0] i_restore_id,
  input logic [PW-1:0] i_head,
  input logic [CW-1:0] i_count
);
  logic [PW-1:0] w_age;
  assign w_age = i_restore_id - i_head;

  // Restore must name a slot that is currently live.
  always @(posedge clk) begin
    if (!rst && i_rdy && i_restore && !i_flush) begin
      assert (CW'(w_age) < i_count);
    end
  end
endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with rename tags, bypassed read ports and checkpointed recovery.
module reg_rename_file import rename_pkg::*; #(
  parameter int XLEN  = RN_XLEN,
  parameter int NRD   = 2,
  parameter int NCKPT = 4,
  localparam int PW = $clog2(NCKPT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   issue_valid,
  input  logic [RN_REG_W-1:0]    issue_rd,
  input  logic [RN_TAG_W-1:0]    issue_tag,
  input  logic [NRD*RN_REG_W-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]    rd_val,
  output logic [NRD-1:0]         rd_busy,
  output logic [NRD*RN_TAG_W-1:0] rd_tag,
  input  logic                   commit_valid,
  input  logic [RN_REG_W-1:0]    commit_rd,
  input  logic [XLEN-1:0]        commit_val,
  input  logic [RN_TAG_W-1:0]    commit_tag,
  input  logic                   flush,
  input  logic                   ckpt_take,
  output logic [PW-1:0]          ckpt_id,
  output logic                   ckpt_full,
  input  logic                   ckpt_release,
  input  logic                   ckpt_restore,
  input  logic [PW-1:0]          ckpt_restore_id
);
  logic [XLEN-1:0] r_val [RN_NREG];
  rn_table_t       r_tbl;
  rn_table_t       w_tbl_n;
  rn_table_t       w_snap;
  logic            w_issue;
  logic            w_commit;
  reg_idx_t        w_a;

  assign w_issue  = issue_valid && (issue_rd != '0) && !flush && !ckpt_restore;
  assign w_commit = commit_valid && (commit_rd != '0);

  // Post-update table: issue wins over a same-register commit.
  always_comb begin
    w_tbl_n = r_tbl;
    for (int r = 0; r < RN_NREG; r++) begin
      if (w_issue && (issue_rd == reg_idx_t'(r))) begin
        w_tbl_n[r] = '{busy: 1'b1, tag: issue_tag};
      end else if (commit_hits(commit_valid, commit_rd, commit_tag, reg_idx_t'(r), r_tbl[r])) begin
        w_tbl_n[r].busy = 1'b0;
      end else begin
        w_tbl_n[r] = r_tbl[r];
      end
    end
  end

  always_comb begin
    rd_val  = '0;
    rd_busy = '0;
    rd_tag  = '0;
    w_a     = '0;
    for (int p = 0; p < NRD; p++) begin
      w_a = rd_addr[p*RN_REG_W +: RN_REG_W];
      if (w_a == '0) begin
        rd_val[p*XLEN +: XLEN]         = '0;
        rd_busy[p]                     = 1'b0;
        rd_tag[p*RN_TAG_W +: RN_TAG_W] = '0;
      end else if (r_tbl[w_a].busy && commit_hits(commit_valid, commit_rd, commit_tag, w_a, r_tbl[w_a])) begin
        rd_val[p*XLEN +: XLEN]         = commit_val;
        rd_busy[p]                     = 1'b0;
        rd_tag[p*RN_TAG_W +: RN_TAG_W] = '0;
      end else begin
        rd_val[p*XLEN +: XLEN]         = r_val[w_a];
        rd_busy[p]                     = r_tbl[w_a].busy;
        rd_tag[p*RN_TAG_W +: RN_TAG_W] = r_tbl[w_a].tag;
      end
    end
  end

  // Commit values land even during flush or restore; tags survive a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < RN_NREG; r++) r_val[r] <= '0;
      r_tbl <= '0;
    end else if (rdy) begin
      if (w_commit) r_val[commit_rd] <= commit_val;
      if (flush) begin
        for (int r = 0; r < RN_NREG; r++) r_tbl[r].busy <= 1'b0;
      end else if (ckpt_restore) begin
        r_tbl <= w_snap;
      end else begin
        r_tbl <= w_tbl_n;
      end
    end
  end

  ckpt_bank #(.NCKPT(NCKPT)) u_ckpt (
    .clk           (clk),
    .rst           (rst),
    .i_rdy         (rdy),
    .i_flush       (flush),
    .i_take        (ckpt_take),
    .i_release     (ckpt_release),
    .i_restore     (ckpt_restore),
    .i_restore_id  (ckpt_restore_id),
    .i_commit_valid(commit_valid),
    .i_commit_rd   (commit_rd),
    .i_commit_tag  (commit_tag),
    .i_table       (w_tbl_n),
    .o_snap        (w_snap),
    .o_tail        (ckpt_id),
    .o_full        (ckpt_full)
  );
endmodule

// File: tb/tb_reg_rename_file.sv
// Randomized bench for reg_rename_file against a queue-of-snapshots reference model.
module tb_reg_rename_file;
  localparam int XLEN = 32, NRD = 2, NCKPT = 4, RW = 5, TW = 4, NR = 32;

  logic clk = 1'b0;
  logic rst, rdy, issue_valid, commit_valid, flush, ckpt_take, ckpt_full, ckpt_release, ckpt_restore;
  logic [RW-1:0] issue_rd, commit_rd;
  logic [TW-1:0] issue_tag, commit_tag;
  logic [NRD*RW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_val;
  logic [NRD-1:0] rd_busy;
  logic [NRD*TW-1:0] rd_tag;
  logic [XLEN-1:0] commit_val;
  logic [1:0] ckpt_id, ckpt_restore_id;

  always #5 clk = ~clk;

  reg_rename_file #(.XLEN(XLEN), .NRD(NRD), .NCKPT(NCKPT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rd_addr(rd_addr), .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val), .commit_tag(commit_tag),
    .flush(flush), .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_release(ckpt_release), .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural state plus an ordered list of live snapshots (oldest first).
  typedef struct packed {
    logic [1:0]       id;
    logic [NR-1:0]    busy;
    logic [NR*TW-1:0] tag;
  } snap_t;

  logic [XLEN-1:0]  m_val [NR];
  logic [NR-1:0]    m_busy;
  logic [NR*TW-1:0] m_tag;
  snap_t            m_q[$];
  int               m_next;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_val[r] = '0;
    m_busy = '0;
    m_tag  = '0;
    m_q.delete();
    m_next = 0;
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NRD; p++) begin
      int a;
      logic [XLEN-1:0] ev;
      logic eb;
      logic [TW-1:0] et;
      a = int'(rd_addr[p*RW +: RW]);
      if (a == 0) begin
        ev = '0; eb = 1'b0; et = '0;
      end else if (commit_valid && int'(commit_rd) == a && m_busy[a] && m_tag[a*TW +: TW] == commit_tag) begin
        ev = commit_val; eb = 1'b0; et = '0;
      end else begin
        ev = m_val[a]; eb = m_busy[a]; et = m_tag[a*TW +: TW];
      end
      check_val($sformatf("rd_val%0d", p), 64'(rd_val[p*XLEN +: XLEN]), 64'(ev));
      check_val($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(eb));
      check_val($sformatf("rd_tag%0d", p), 64'(rd_tag[p*TW +: TW]), 64'(et));
    end
    check_val("ckpt_id", 64'(ckpt_id), 64'(m_next));
    check_val("ckpt_full", 64'(ckpt_full), 64'(m_q.size() == NCKPT));
  endtask

  task automatic model_update();
    logic [NR-1:0] nb;
    logic [NR*TW-1:0] nt;
    int crd, ird, j;
    logic cm, rel, tk;
    snap_t s;
    if (!rdy) return;
    crd = int'(commit_rd);
    ird = int'(issue_rd);
    cm  = commit_valid && crd != 0;
    nb  = m_busy;
    nt  = m_tag;
    if (cm && m_tag[crd*TW +: TW] == commit_tag) nb[crd] = 1'b0;
    if (issue_valid && ird != 0 && !flush && !ckpt_restore) begin
      nb[ird] = 1'b1;
      nt[ird*TW +: TW] = issue_tag;
    end
    for (int i = 0; i < m_q.size(); i++) begin
      s = m_q[i];
      if (cm && s.tag[crd*TW +: TW] == commit_tag) s.busy[crd] = 1'b0;
      m_q[i] = s;
    end
    if (cm) m_val[crd] = commit_val;
    if (flush) begin
      m_busy = '0;
      m_q.delete();
      m_next = 0;
    end else if (ckpt_restore) begin
      if (ckpt_release && m_q.size() > 0) void'(m_q.pop_front());
      j = -1;
      for (int i = 0; i < m_q.size(); i++) if (m_q[i].id == ckpt_restore_id) j = i;
      if (j >= 0) begin
        m_busy = m_q[j].busy;
        m_tag  = m_q[j].tag;
        while (m_q.size() > j) void'(m_q.pop_back());
      end
      m_next = int'(ckpt_restore_id);
    end else begin
      rel = ckpt_release && m_q.size() > 0;
      tk  = ckpt_take && m_q.size() < NCKPT;
      m_busy = nb;
      m_tag  = nt;
      if (rel) void'(m_q.pop_front());
      if (tk) begin
        m_q.push_back('{id: 2'(m_next), busy: nb, tag: nt});
        m_next = (m_next + 1) % NCKPT;
      end
    end
  endtask

  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_val = '0; commit_tag = '0;
    flush = 1'b0; ckpt_take = 1'b0; ckpt_release = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = {5'd0, 5'd5};
    idle();
    model_reset();
    @(negedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Reset reads, then a plain issue.
    #1 check_val("rst_x5_busy", 64'(rd_busy[0]), 64'd0);
    check_val("rst_x0_val", 64'(rd_val[63:32]), 64'd0);
    step();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_tag = 4'd3;
    step();
    idle();
    #1 check_val("x5_busy", 64'(rd_busy[0]), 64'd1);
    check_val("x5_tag", 64'(rd_tag[3:0]), 64'd3);
    step();

    // Commit bypass on the read port, then the stored value.
    commit_valid = 1'b1; commit_rd = 5'd5; commit_tag = 4'd3; commit_val = 32'hDEAD;
    #1 check_val("byp_val", 64'(rd_val[31:0]), 64'hDEAD);
    check_val("byp_busy", 64'(rd_busy[0]), 64'd0);
    step();
    idle();
    #1 check_val("x5_stored", 64'(rd_val[31:0]), 64'hDEAD);
    check_val("x5_idle", 64'(rd_busy[0]), 64'd0);
    step();

    // Same-cycle issue and stale commit on x7.
    rd_addr = {5'd0, 5'd7};
    issue_valid = 1'b1; issue_rd = 5'd7; issue_tag = 4'd9;
    commit_valid = 1'b1; commit_rd = 5'd7; commit_tag = 4'd2; commit_val = 32'h11;
    step();
    idle();
    #1 check_val("x7_val", 64'(rd_val[31:0]), 64'h11);
    check_val("x7_busy", 64'(rd_busy[0]), 64'd1);
    check_val("x7_tag", 64'(rd_tag[3:0]), 64'd9);
    step();

    // Restore of a snapshot scrubbed by a same-cycle commit.
    rd_addr = {5'd0, 5'd1};
    issue_valid = 1'b1; issue_rd = 5'd1; issue_tag = 4'd1;
    step();
    idle();
    ckpt_take = 1'b1;
    #1 check_val("take_id", 64'(ckpt_id), 64'd0);
    step();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd1; issue_tag = 4'd4;
    step();
    idle();
    commit_valid = 1'b1; commit_rd = 5'd1; commit_tag = 4'd1; commit_val = 32'h55;
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
    step();
    idle();
    #1 check_val("rest_busy", 64'(rd_busy[0]), 64'd0);
    check_val("rest_val", 64'(rd_val[31:0]), 64'h55);
    check_val("rest_full", 64'(ckpt_full), 64'd0);
    step();

    // Fill, overflow, release.
    for (int i = 0; i < 5; i++) begin
      ckpt_take = 1'b1;
      step();
    end
    idle();
    #1 check_val("full", 64'(ckpt_full), 64'd1);
    check_val("full_id", 64'(ckpt_id), 64'd0);
    ckpt_release = 1'b1;
    step();
    idle();
    #1 check_val("rel_full", 64'(ckpt_full), 64'd0);
    check_val("rel_id", 64'(ckpt_id), 64'd0);

    // Flush with three live slots plus same-cycle issue and commit.
    rd_addr = {5'd2, 5'd3};
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd2; issue_tag = 4'd5;
    commit_valid = 1'b1; commit_rd = 5'd3; commit_tag = 4'd0; commit_val = 32'd7;
    step();
    idle();
    #1 check_val("fl_x3", 64'(rd_val[31:0]), 64'd7);
    check_val("fl_x2", 64'(rd_busy[1]), 64'd0);
    check_val("fl_id", 64'(ckpt_id), 64'd0);
    step();

    // Randomized traffic with one asynchronous reset mid-run.
    for (int i = 0; i < 3000; i++) begin
      rdy          = ($urandom_range(0, 9) != 0);
      issue_valid  = $urandom_range(0, 1) == 1;
      issue_rd     = 5'($urandom_range(0, 7));
      issue_tag    = 4'($urandom);
      commit_valid = $urandom_range(0, 1) == 1;
      commit_rd    = 5'($urandom_range(0, 7));
      commit_tag   = ($urandom_range(0, 2) != 0) ? m_tag[int'(commit_rd)*TW +: TW] : 4'($urandom);
      commit_val   = $urandom;
      flush        = ($urandom_range(0, 39) == 0);
      ckpt_take    = ($urandom_range(0, 3) == 0);
      ckpt_release = ($urandom_range(0, 5) == 0);
      ckpt_restore = 1'b0;
      ckpt_restore_id = 2'($urandom);
      if (m_q.size() > 0 && $urandom_range(0, 9) == 0) begin
        ckpt_restore    = 1'b1;
        ckpt_release    = 1'b0;
        ckpt_restore_id = m_q[$urandom_range(0, m_q.size() - 1)].id;
      end
      rd_addr = {5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) ? commit_rd : 5'($urandom_range(0, 7))};
      if (i == 1500) begin
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_rename_file.md
# reg_rename_file

Parametrised architectural register file with per-register ROB rename tags, NRD combinational read ports with commit bypass, and a circular bank of NCKPT rename-table checkpoints for single-cycle branch-mispredict recovery. It sits between the dispatcher (issue, operand read, checkpoint take) and the ROB (commit, flush, checkpoint release/restore).

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers; x0 hard-wired to zero
- TAG_W, 4, ROB tag width
- NRD, 2, read ports
- NCKPT, 4, checkpoint slots (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; when low, all state holds
- issue_valid  in  1  rename issue_rd to issue_tag
- issue_rd  in  $clog2(NREG)  destination register
- issue_tag  in  TAG_W  ROB tag of the issuing instruction
- rd_addr  in  NRD*$clog2(NREG)  read addresses, packed, port 0 in the LSBs
- rd_val  out  NRD*XLEN  read values
- rd_busy  out  NRD  1 = value pending, use rd_tag
- rd_tag  out  NRD*TAG_W  producing ROB tag
- commit_valid  in  1  ROB commit
- commit_rd  in  $clog2(NREG)  committed register
- commit_val  in  XLEN  committed value
- commit_tag  in  TAG_W  committed ROB tag
- flush  in  1  full pipeline clear
- ckpt_take  in  1  snapshot rename table (branch issue)
- ckpt_id  out  $clog2(NCKPT)  slot the next take will use
- ckpt_full  out  1  all slots live
- ckpt_release  in  1  free the oldest live slot (branch resolved correct)
- ckpt_restore  in  1  mispredict recovery
- ckpt_restore_id  in  $clog2(NCKPT)  slot to restore

## Operation
- State: val[NREG], busy[NREG], tag[NREG]; per slot snap_busy/snap_tag; head, tail, count (width $clog2(NCKPT+1)).
- Read port p: addr 0 → val 0, busy 0, tag 0. If commit_valid, commit_rd==addr≠0, busy[addr] and tag[addr]==commit_tag → val=commit_val, busy 0, tag 0. Otherwise the stored val/busy/tag.
- Commit (commit_rd≠0): val written unconditionally, including during flush or restore. busy cleared only if tag matches and there is no same-cycle issue to the same rd. In every live snapshot, snap_busy[commit_rd] is cleared if snap_tag matches.
- Issue (issue_rd≠0, no flush/restore): busy←1, tag←issue_tag. Issue beats commit on the same rd.
- Priority: flush > restore > normal (issue/take).
- Flush: all busy cleared; head=tail=count=0; issue, take, release and restore are ignored.
- Take (not full): slot tail ← post-update table (this cycle's issue and commit applied); tail+1 mod NCKPT; count+1. A take while full is dropped with no state change.
- Release (count>0): head+1, count−1. Release with count 0 is ignored.
- Restore: busy/tag ← snapshot[id], with this cycle's commit clearing a matching entry. Slot id and all younger slots are freed: tail=id, count=(id−head) mod NCKPT after any same-cycle release. Same-cycle issue and take are ignored. Restoring a non-live id is illegal and is flagged by an assertion.
- Width rules: tag compare is exact TAG_W. Pointers wrap modulo NCKPT.

## Timing
- Reads are combinational, zero latency, and independent of rdy. Writes, issue, take and restore are visible on the next cycle's reads.
- ckpt_id = tail and ckpt_full = (count==NCKPT) are registered-state derived and valid in the same cycle.
- Reset values: every val 0, busy 0, tag 0; every snapshot 0; head=tail=count=0. Outputs: rd_val 0, rd_busy 0, rd_tag 0, ckpt_id 0, ckpt_full 0.
- Reset asserted mid-operation clears all state immediately, regardless of rdy.

## Structure
- Shared package rename_pkg holds: the XLEN/TAG_W/NREG defaults, the reg-index typedef, the ROB-tag typedef, and the packed {busy, tag} entry struct.
- One natural sub-module, ckpt_bank, contains the NCKPT snapshot arrays, head/tail/count, and the commit-scrub logic. The top level keeps the value file, the live rename table and the read ports.

## Test plan
- Reset, then read x5 and x0 → val 0, busy 0. Issue x5 tag 3, then read x5 → busy 1, tag 3.
- With x5 busy tag 3, commit x5 tag 3 val 0xDEAD in the same cycle as the read → port returns 0xDEAD, busy 0. Next cycle the stored value is 0xDEAD and busy is 0.
- Same cycle: issue x7 tag 9 and commit x7 tag 2 val 0x11 → next cycle val 0x11, busy 1, tag 9.
- Issue x1 tag 1, take (ckpt_id 0), issue x1 tag 4, commit x1 tag 1, restore id 0 → x1 busy 0 (the snapshot was scrubbed), count 0.
- Take 4 times → ckpt_full 1; a fifth take is dropped. Release → full 0, ckpt_id stays 0 because tail has wrapped.
- With 3 slots live, assert flush together with issue x2 tag 5 and commit x3 val 7 → all busy 0, count 0, x3 val 7, x2 not busy.
